// File: rtl/cook_ctrl.sv
`timescale 1ns/1ps
// cook_ctrl: microwave cooking sequencer with start-edge detection, pause/resume,
// a tick-counted DONE hold period and a duty-cycled magnetron enable.
module cook_ctrl #(
  parameter int LEVELS     = 4,
  parameter int DONE_TICKS = 3,
  parameter int LW         = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          startn,
  input  logic          stopn,
  input  logic          clearn,
  input  logic          door_closed,
  input  logic          timer_done,
  input  logic          tick,
  input  logic [LW-1:0] power_sel,
  output logic [1:0]    state,
  output logic          cooking,
  output logic          mag_on,
  output logic          done
);

  localparam int HW = $clog2(DONE_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] duty_q, duty_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          start_prev_q, start_prev_d;
  logic          start_armed_q, start_armed_d;
  logic          mag_on_q, mag_on_d;

  logic          start_evt;
  logic          start_ok;
  logic [LW-1:0] power_lvl;
  logic [LW-1:0] duty_next;
  logic [HW-1:0] hold_inc;

  // The armed flag blocks a start event until startn has been seen high once
  // after reset, so a button held through reset release does not start cooking.
  always_comb begin
    start_prev_d  = startn;
    start_armed_d = start_armed_q | startn;
    start_evt     = start_armed_q & start_prev_q & ~startn;
    start_ok      = start_evt & door_closed & stopn & clearn & ~timer_done;
    power_lvl     = ({1'b0, power_sel} >= (LW+1)'(LEVELS)) ? LW'(LEVELS - 1) : power_sel;
    duty_next     = (duty_q == LW'(LEVELS - 1)) ? '0 : duty_q + LW'(1);
    hold_inc      = hold_q + HW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lvl_q         <= '0;
      duty_q        <= '0;
      hold_q        <= '0;
      start_prev_q  <= 1'b1;
      start_armed_q <= 1'b0;
      mag_on_q      <= 1'b0;
    end else begin
      lvl_q         <= lvl_d;
      duty_q        <= duty_d;
      hold_q        <= hold_d;
      start_prev_q  <= start_prev_d;
      start_armed_q <= start_armed_d;
      mag_on_q      <= mag_on_d;
    end
  end

  // The duty counter only advances on a tick when COOK is held; any
  // transition out of COOK on the same edge swallows the tick.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (start_ok) begin
          state_d = COOK;
          lvl_d   = power_lvl;
          duty_d  = '0;
        end
      end
      COOK: begin
        hold_d = '0;
        if (!clearn) begin
          state_d = IDLE;
        end else if (timer_done) begin
          state_d = DONE;
        end else if (!stopn || !door_closed) begin
          state_d = PAUSE;
        end else if (tick) begin
          duty_d = duty_next;
        end
      end
      PAUSE: begin
        hold_d = '0;
        if (!clearn) begin
          state_d = IDLE;
        end else if (timer_done) begin
          state_d = DONE;
        end else if (start_ok) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (!clearn || !door_closed) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_inc == HW'(DONE_TICKS)) begin
            state_d = IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // mag_on looks at next-state values so it drops on the very edge COOK is left.
  always_comb begin
    mag_on_d = (state_d == COOK) && (duty_d <= lvl_d);
    state    = state_q;
    cooking  = (state_q == COOK);
    done     = (state_q == DONE);
    mag_on   = mag_on_q;
  end

  mag_only_in_cook: assert property (@(posedge clk) disable iff (!resetn)
    mag_on_q |-> (state_q == COOK));
  duty_in_range: assert property (@(posedge clk) disable iff (!resetn)
    (duty_q <= LW'(LEVELS - 1)) && (lvl_q <= LW'(LEVELS - 1)));
  hold_in_range: assert property (@(posedge clk) disable iff (!resetn)
    hold_q < HW'(DONE_TICKS));

endmodule

// File: doc/cook_ctrl.md
COOK_CTRL -- requirements
Module: cook_ctrl

Interface
REQ-001 Parameter LEVELS, default 4, number of power levels (>=2); level LEVELS-1 is full power.
REQ-002 Parameter DONE_TICKS, default 3, number of tick pulses the DONE state is held before the block returns to IDLE (>=1).
REQ-003 Parameter LW, default $clog2(LEVELS), width of power_sel and of the duty counter.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 startn  input  1  start/resume button, active-low.
REQ-007 stopn  input  1  stop/pause request, active-low, level-sensitive.
REQ-008 clearn  input  1  clear/abort request, active-low, level-sensitive.
REQ-009 door_closed  input  1  1 = door closed.
REQ-010 timer_done  input  1  countdown timer reached zero, level.
REQ-011 tick  input  1  one-cycle timebase enable (e.g. 1 Hz).
REQ-012 power_sel  input  LW  requested power level, 0..LEVELS-1.
REQ-013 state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-014 cooking  output  1  high exactly when state==COOK.
REQ-015 mag_on  output  1  magnetron enable, registered.
REQ-016 done  output  1  high exactly when state==DONE.

Function
REQ-017 Start event: registered falling edge of startn (previous sample 1, current sample 0); holding startn low SHALL produce only one event.
REQ-018 Start qualifier: start event AND door_closed AND stopn AND clearn AND !timer_done; unqualified events SHALL be discarded, not queued.
REQ-019 IDLE -> COOK on the clock edge sampling a qualified start; power_sel latched into lvl on that edge; duty counter cleared to 0.
REQ-020 COOK priority, highest first: clearn=0 -> IDLE; timer_done=1 -> DONE; stopn=0 or door_closed=0 -> PAUSE; else remain COOK.
REQ-021 PAUSE: clearn=0 -> IDLE; timer_done=1 -> DONE; qualified start -> COOK (resume) with lvl and duty counter preserved; else remain PAUSE.
REQ-022 DONE: clearn=0 or door_closed=0 -> IDLE immediately; otherwise hold counter increments on each tick and state -> IDLE on the tick that makes it reach DONE_TICKS; start events ignored in DONE.
REQ-023 Duty counter advances only in COOK on tick, counting 0..LEVELS-1 and wrapping to 0; frozen in PAUSE.
REQ-024 mag_on SHALL be registered high on the next edge iff next state is COOK and duty counter (next value) <= lvl; lvl=LEVELS-1 gives continuous on; lvl=0 gives 1 tick in LEVELS.
REQ-025 power_sel changes while in COOK/PAUSE SHALL be ignored until the next IDLE -> COOK transition.
REQ-026 power_sel values >= LEVELS SHALL be saturated to LEVELS-1 when latched.
REQ-027 mag_on SHALL drop on the same edge the state leaves COOK (no extra cycle of magnetron on with door open).
REQ-028 tick coincident with a state-changing event: state transition takes effect; duty counter not advanced on that edge.

Reset
REQ-029 resetn=0 SHALL immediately force state=IDLE, cooking=0, mag_on=0, done=0, lvl=0, duty counter=0, DONE hold counter=0, startn history=1.
REQ-030 Reset asserted mid-COOK SHALL drop mag_on asynchronously without waiting for a clock edge.
REQ-031 After resetn release with startn already low, no start event SHALL occur until startn returns high and falls again.

Verification
REQ-032 Door open, startn pulsed low -> state stays IDLE; close door, hold startn low -> state=COOK next edge; continued hold produces no further events.
REQ-033 LEVELS=4, power_sel=1, 8 ticks in COOK -> mag_on pattern 1,1,0,0,1,1,0,0 per tick period; power_sel=3 -> mag_on constant 1.
REQ-034 COOK, open door -> PAUSE and mag_on=0 on same edge; close door, startn pulse -> COOK with duty counter continuing from frozen value.
REQ-035 COOK with clearn=0 and timer_done=1 simultaneously -> IDLE (clear wins); separately, timer_done=1 -> DONE, done=1 held exactly 3 ticks, then IDLE.
REQ-036 stopn=0, clearn=0, or timer_done=1 held while startn pulsed from IDLE -> state remains IDLE, cooking=0, mag_on=0.
REQ-037 resetn=0 asserted mid-COOK between clock edges -> mag_on, cooking fall immediately; state=IDLE.
